// File: rtl/jtcps1_obj_frame.sv
// CPS-1 object table frame cache: copies 1024 VRAM words into a local RAM for the line-table stage.
// Define JTCPS1_OBJ_DBLBUF_EN to keep two banks so readers only ever see a complete table.
module jtcps1_obj_frame #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] obj_base,
    output logic [17:1] vram_addr,
    output logic        vram_cs,
    input  logic [15:0] vram_data,
    input  logic        vram_ok,
    input  logic [AW-1:0] frame_addr,
    output logic [15:0] frame_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_WRITE
    } state_t;

`ifdef JTCPS1_OBJ_DBLBUF_EN
    localparam int IW = AW + 1;
`else
    localparam int IW = AW;
`endif
    localparam int DEPTH = 2 ** IW;

    state_t        r_state;
    state_t        w_next;
    logic [16:0]   r_base;
    logic [16:0]   r_addr;
    logic [AW-1:0] r_cnt;
    logic [15:0]   r_data;
    logic [15:0]   r_fdata;
    logic [15:0]   r_mem [0:DEPTH-1];

    logic [16:0]   w_new_base;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_last;
    logic          w_wr;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_unused_base;

    assign w_new_base    = {obj_base[9:0], 7'd0};
    assign w_unused_base = ^obj_base[15:10];
    assign w_cnt_nxt     = r_cnt + AW'(1);
    assign w_last        = (r_cnt == '1);
    // A start in the WRITE cycle discards the word in flight.
    assign w_wr          = (r_state == S_WRITE) && !start;

`ifdef JTCPS1_OBJ_DBLBUF_EN
    logic r_bank;
    logic r_done;

    assign w_wr_idx = {r_bank, r_cnt};
    assign w_rd_idx = {~r_bank, frame_addr};

    // The bank flips only after a finished copy, so an aborted one is never shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            if (r_done) r_bank <= ~r_bank;
            r_done <= 1'b0;
        end else if (w_wr && w_last) begin
            r_done <= 1'b1;
        end
    end
`else
    assign w_wr_idx = r_cnt;
    assign w_rd_idx = frame_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ADDR;
            // vram_ok may still be high from the previous word here, so it is not looked at.
            S_ADDR:  w_next = S_WAIT;
            S_WAIT:  if (vram_ok) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_IDLE : S_ADDR;
            default: w_next = S_IDLE;
        endcase
        if (start) w_next = S_ADDR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_fdata <= '0;
        end else begin
            r_fdata <= r_mem[w_rd_idx];
            if (start) begin
                r_base <= w_new_base;
                r_addr <= w_new_base;
                r_cnt  <= '0;
            end else begin
                case (r_state)
                    S_WAIT: if (vram_ok) r_data <= vram_data;
                    S_WRITE: begin
                        r_cnt  <= w_cnt_nxt;
                        r_addr <= r_base + {{(17-AW){1'b0}}, w_cnt_nxt};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Cache contents survive reset; only the copy engine is cleared.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_wr_idx] <= r_data;
    end

    assign vram_addr  = r_addr;
    assign vram_cs    = (r_state != S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign frame_data = r_fdata;

endmodule
